// File: rtl/usb_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_transmitter_if
// Description : Bundles the TX FIFO handshake and USB pad signals of the
//               full-speed USB transmitter.
//               master : the TX FIFO / packet-request side plus pad observer
//               slave  : the transmitter itself
//   tx_start      request to send a packet (master -> slave)
//   fifo_empty    TX FIFO empty flag (master -> slave)
//   fifo_r_data   TX FIFO head byte, first-word-fall-through (master -> slave)
//   fifo_r_enable one-cycle pop strobe (slave -> master)
//   d_plus        positive USB line (slave -> master)
//   d_minus       negative USB line (slave -> master)
//   transmitting  high while a packet is on the wire (slave -> master)
// Revision    : 1.0  initial release
// ============================================================================
interface usb_transmitter_if;
  logic       tx_start;
  logic       fifo_empty;
  logic [7:0] fifo_r_data;
  logic       fifo_r_enable;
  logic       d_plus;
  logic       d_minus;
  logic       transmitting;

  modport master (
    output tx_start,
    output fifo_empty,
    output fifo_r_data,
    input  fifo_r_enable,
    input  d_plus,
    input  d_minus,
    input  transmitting
  );

  modport slave (
    input  tx_start,
    input  fifo_empty,
    input  fifo_r_data,
    output fifo_r_enable,
    output d_plus,
    output d_minus,
    output transmitting
  );
endinterface
`default_nettype wire

// File: rtl/usb_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : usb_transmitter
// Description : Serializes bytes from a first-word-fall-through TX FIFO into a
//               full-speed USB packet: SYNC, NRZI-encoded data (LSB first, no
//               bit stuffing), EOP (SE0, SE0, J). Pad outputs are registered.
// Ports       : clk  - system clock (96 MHz), rising edge
//               rst  - synchronous active-high reset
//               bus  - usb_transmitter_if.slave (FIFO handshake + pads)
// Parameters  : CLKS_PER_BIT - clocks per USB bit time, must be >= 2
// Revision    : 1.0  initial release
// ============================================================================
module usb_transmitter #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  usb_transmitter_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] c_cnt_max      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_cnt_one      = CW'(1);
  localparam logic [7:0]    c_sync_pattern = 8'h80;

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_sync    = 3'd1;
  localparam logic [2:0] c_data    = 3'd2;
  localparam logic [2:0] c_eop_se0 = 3'd3;
  localparam logic [2:0] c_eop_j   = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_level;        // NRZI level for J/K: 1 = J, 0 = K
  logic          r_d_plus;
  logic          r_d_minus;
  logic          r_transmitting;

  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_clk_cnt_nxt;
  logic [2:0]    w_bit_cnt_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_level_nxt;
  logic          w_dp_nxt;
  logic          w_dm_nxt;
  logic          w_tx_nxt;
  logic          w_pop;
  logic          w_drive_bit;
  logic          w_bit_val;
  logic          w_bit_end;
  logic          w_byte_end;
  logic [2:0]    w_bit_idx;

  assign w_bit_end  = (r_clk_cnt == c_cnt_max);
  assign w_byte_end = w_bit_end && (r_bit_cnt == 3'd7);
  assign w_bit_idx  = r_bit_cnt + 3'd1;

  // --------------------------------------------------------------------------
  // State register: state, counters, shift register, NRZI level and the
  // registered pad outputs all update together, so the line changes on the
  // same edge as the state that owns it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= c_idle;
      r_clk_cnt      <= '0;
      r_bit_cnt      <= 3'd0;
      r_shift        <= 8'h00;
      r_level        <= 1'b1;
      r_d_plus       <= 1'b1;
      r_d_minus      <= 1'b0;
      r_transmitting <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_clk_cnt      <= w_clk_cnt_nxt;
      r_bit_cnt      <= w_bit_cnt_nxt;
      r_shift        <= w_shift_nxt;
      r_level        <= w_level_nxt;
      r_d_plus       <= w_dp_nxt;
      r_d_minus      <= w_dm_nxt;
      r_transmitting <= w_tx_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_cnt_nxt = r_bit_cnt;

    if (r_state != c_idle) begin
      if (w_bit_end) begin
        w_clk_cnt_nxt = '0;
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
      end else begin
        w_clk_cnt_nxt = r_clk_cnt + c_cnt_one;
      end
    end

    case (r_state)
      c_idle: begin
        if (bus.tx_start && !bus.fifo_empty) begin
          w_state_nxt = c_sync;
        end
      end
      c_sync, c_data: begin
        // The FIFO is checked only in the final clock of the byte; a byte
        // arriving after that belongs to the next packet.
        if (w_byte_end) begin
          w_state_nxt = bus.fifo_empty ? c_eop_se0 : c_data;
        end
      end
      c_eop_se0: begin
        if (w_bit_end && (r_bit_cnt == 3'd1)) begin
          w_state_nxt = c_eop_j;
        end
      end
      c_eop_j: begin
        if (w_bit_end) begin
          w_state_nxt = c_idle;
        end
      end
      default: begin
        w_state_nxt = c_idle;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_clk_cnt_nxt = '0;
      w_bit_cnt_nxt = 3'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: pop strobe, shift-register load and next pad levels
  // --------------------------------------------------------------------------
  always_comb begin
    w_pop       = 1'b0;
    w_shift_nxt = r_shift;
    w_level_nxt = r_level;
    w_dp_nxt    = r_d_plus;
    w_dm_nxt    = r_d_minus;
    w_tx_nxt    = r_transmitting;
    w_drive_bit = 1'b0;
    w_bit_val   = 1'b0;

    case (r_state)
      c_idle: begin
        w_dp_nxt    = 1'b1;
        w_dm_nxt    = 1'b0;
        w_level_nxt = 1'b1;
        w_tx_nxt    = 1'b0;
        if (w_state_nxt == c_sync) begin
          w_shift_nxt = c_sync_pattern;
          w_bit_val   = c_sync_pattern[0];
          w_drive_bit = 1'b1;
          w_tx_nxt    = 1'b1;
        end
      end
      c_sync, c_data: begin
        if (w_byte_end) begin
          if (w_state_nxt == c_data) begin
            // FWFT head byte is captured on the same edge the pop retires it
            w_pop       = 1'b1;
            w_shift_nxt = bus.fifo_r_data;
            w_bit_val   = bus.fifo_r_data[0];
            w_drive_bit = 1'b1;
          end else begin
            w_dp_nxt = 1'b0;
            w_dm_nxt = 1'b0;
          end
        end else if (w_bit_end) begin
          w_bit_val   = r_shift[w_bit_idx];
          w_drive_bit = 1'b1;
        end
      end
      c_eop_se0: begin
        if (w_state_nxt == c_eop_j) begin
          w_dp_nxt    = 1'b1;
          w_dm_nxt    = 1'b0;
          w_level_nxt = 1'b1;
        end
      end
      c_eop_j: begin
        if (w_state_nxt == c_idle) begin
          w_dp_nxt = 1'b1;
          w_dm_nxt = 1'b0;
          w_tx_nxt = 1'b0;
        end
      end
      default: begin
        w_dp_nxt    = 1'b1;
        w_dm_nxt    = 1'b0;
        w_level_nxt = 1'b1;
        w_tx_nxt    = 1'b0;
      end
    endcase

    // NRZI: a 0 toggles the line, a 1 holds it
    if (w_drive_bit) begin
      w_level_nxt = w_bit_val ? r_level : ~r_level;
      w_dp_nxt    = w_level_nxt;
      w_dm_nxt    = ~w_level_nxt;
    end
  end

  assign bus.fifo_r_enable = w_pop;
  assign bus.d_plus        = r_d_plus;
  assign bus.d_minus       = r_d_minus;
  assign bus.transmitting  = r_transmitting;

endmodule
`default_nettype wire

// File: tb/tb_usb_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_transmitter
// Description : Directed self-checking bench for usb_transmitter. A small
//               FWFT FIFO model feeds the DUT; each packet is captured cycle
//               by cycle and compared to hand-derived line symbols.
// Revision    : 1.0  initial release
// ============================================================================
module tb_usb_transmitter;

  localparam int C = 8;

  localparam logic [1:0] J  = 2'b10;
  localparam logic [1:0] K  = 2'b01;
  localparam logic [1:0] S0 = 2'b00;

  logic clk;
  logic rst;

  usb_transmitter_if bus ();

  usb_transmitter #(.CLKS_PER_BIT(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FWFT FIFO model
  logic [7:0] fifo_mem [16];
  int rd;
  int wr;
  int pop_total;
  int bad_pops;

  assign bus.fifo_empty  = (rd == wr);
  assign bus.fifo_r_data = fifo_mem[rd[3:0]];

  always @(posedge clk) begin
    if (bus.fifo_r_enable === 1'b1) begin
      pop_total <= pop_total + 1;
      if (rd == wr) bad_pops <= bad_pops + 1;
      else          rd <= rd + 1;
    end
  end

  int checks;
  int errors;

  // capture results
  logic [1:0] cap_sym [600];
  int cap_len;
  int cap_pops;
  int cap_pop_cyc [8];

  task automatic push(input logic [7:0] b);
    fifo_mem[wr[3:0]] = b;
    wr = wr + 1;
  endtask

  task automatic start_pkt();
    bus.tx_start = 1'b1;
    @(posedge clk);
    #1 bus.tx_start = 1'b0;
  endtask

  // Captures from the cycle after the start edge until transmitting drops.
  task automatic capture(input int pulse_at, input int refill_at, input logic [7:0] refill_byte);
    cap_len  = -1;
    cap_pops = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.tx_start = (i == pulse_at);
      if (i == refill_at) push(refill_byte);
      cap_sym[i] = {bus.d_plus, bus.d_minus};
      if (bus.fifo_r_enable === 1'b1) begin
        if (cap_pops < 8) cap_pop_cyc[cap_pops] = i;
        cap_pops++;
      end
      if (bus.transmitting !== 1'b1) begin
        cap_len = i;
        break;
      end
    end
    bus.tx_start = 1'b0;
  endtask

  function automatic bit bit_ok(input int b, input logic [1:0] want);
    bit ok;
    ok = 1'b1;
    for (int c = 0; c < C; c++) begin
      if (cap_sym[b*C + c] !== want) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.tx_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.d_plus, bus.d_minus} !== J) begin
      errors++; $display("FAIL reset_line got %b want %b", {bus.d_plus, bus.d_minus}, J);
    end
    checks++;
    if (bus.transmitting !== 1'b0) begin
      errors++; $display("FAIL reset_transmitting got %b want 0", bus.transmitting);
    end
    checks++;
    if (bus.fifo_r_enable !== 1'b0) begin
      errors++; $display("FAIL reset_pop got %b want 0", bus.fifo_r_enable);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_byte();
    logic [1:0] e [19];
    int p0;
    e = '{K, J, K, J, K, J, K, K, K, J, J, K, J, J, K, K, S0, S0, J};
    p0 = pop_total;
    push(8'hA5);
    @(negedge clk);
    start_pkt();
    capture(-1, -1, 8'h00);
    checks++;
    if (cap_len !== 152) begin
      errors++; $display("FAIL single_len got %0d want 152", cap_len);
    end
    for (int b = 0; b < 19; b++) begin
      checks++;
      if (!bit_ok(b, e[b])) begin
        errors++; $display("FAIL single_bit%0d got %b want %b", b, cap_sym[b*C + C/2], e[b]);
      end
    end
    checks++;
    if (cap_sym[(cap_len < 0) ? 0 : cap_len] !== J) begin
      errors++; $display("FAIL single_idle_line got %b want %b", cap_sym[(cap_len < 0) ? 0 : cap_len], J);
    end
    checks++;
    if (cap_pops !== 1 || (pop_total - p0) !== 1) begin
      errors++; $display("FAIL single_pops got %0d want 1", cap_pops);
    end
    checks++;
    if (cap_pop_cyc[0] !== 63) begin
      errors++; $display("FAIL single_pop_cycle got %0d want 63", cap_pop_cyc[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e [27];
    e = '{K, J, K, J, K, J, K, K,
          J, K, J, K, J, K, J, K,
          K, K, K, K, K, K, K, K,
          S0, S0, J};
    push(8'h00);
    push(8'hFF);
    @(negedge clk);
    start_pkt();
    capture(-1, -1, 8'h00);
    checks++;
    if (cap_len !== 216) begin
      errors++; $display("FAIL b2b_len got %0d want 216", cap_len);
    end
    for (int b = 0; b < 27; b++) begin
      checks++;
      if (!bit_ok(b, e[b])) begin
        errors++; $display("FAIL b2b_bit%0d got %b want %b", b, cap_sym[b*C + C/2], e[b]);
      end
    end
    checks++;
    if (cap_pops !== 2) begin
      errors++; $display("FAIL b2b_pops got %0d want 2", cap_pops);
    end
    checks++;
    if (cap_pop_cyc[0] !== 63 || cap_pop_cyc[1] !== 127) begin
      errors++; $display("FAIL b2b_pop_cycles got %0d,%0d want 63,127", cap_pop_cyc[0], cap_pop_cyc[1]);
    end
    // Earliest restart: request in the first IDLE cycle
    push(8'hA5);
    start_pkt();
    capture(-1, -1, 8'h00);
    checks++;
    if (cap_len !== 152 || cap_sym[0] !== K) begin
      errors++; $display("FAIL restart got len %0d first %b want 152 %b", cap_len, cap_sym[0], K);
    end
  endtask

  task automatic test_empty_start();
    int p0;
    bit bad;
    p0  = pop_total;
    bad = 1'b0;
    @(negedge clk);
    bus.tx_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.tx_start = 1'b0;
      if (bus.transmitting !== 1'b0 || {bus.d_plus, bus.d_minus} !== J) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL empty_start got tx %b line %b want 0 %b", bus.transmitting, {bus.d_plus, bus.d_minus}, J);
    end
    checks++;
    if (pop_total !== p0) begin
      errors++; $display("FAIL empty_start_pops got %0d want 0", pop_total - p0);
    end
  endtask

  task automatic test_start_ignored();
    bit bad;
    push(8'h00);
    push(8'hFF);
    @(negedge clk);
    start_pkt();
    capture(100, -1, 8'h00);
    checks++;
    if (cap_len !== 216 || cap_pops !== 2) begin
      errors++; $display("FAIL ignored_start got len %0d pops %0d want 216 2", cap_len, cap_pops);
    end
    // Data waiting but no new request: must stay idle
    push(8'h3C);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.transmitting !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || bus.fifo_empty !== 1'b0) begin
      errors++; $display("FAIL no_request_idle got tx_seen %b empty %b want 0 0", bad, bus.fifo_empty);
    end
    wr = rd;
  endtask

  task automatic test_late_refill();
    push(8'hA5);
    @(negedge clk);
    start_pkt();
    // cycle 127 is the EOP decision clock; refill right after it
    capture(-1, 128, 8'h5A);
    checks++;
    if (cap_len !== 152 || cap_pops !== 1) begin
      errors++; $display("FAIL late_refill got len %0d pops %0d want 152 1", cap_len, cap_pops);
    end
    checks++;
    if (cap_sym[128] !== S0 || cap_sym[151] !== J) begin
      errors++; $display("FAIL late_refill_eop got %b,%b want %b,%b", cap_sym[128], cap_sym[151], S0, J);
    end
    checks++;
    if (bus.fifo_empty !== 1'b0 || bus.fifo_r_data !== 8'h5A) begin
      errors++; $display("FAIL late_refill_left got empty %b data %h want 0 5a", bus.fifo_empty, bus.fifo_r_data);
    end
    wr = rd;
  endtask

  task automatic test_reset_mid_data();
    logic [1:0] e [8];
    e = '{K, J, K, J, K, J, K, K};
    push(8'h00);
    push(8'hFF);
    @(negedge clk);
    start_pkt();
    repeat (80) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.d_plus, bus.d_minus} !== J || bus.transmitting !== 1'b0 || bus.fifo_r_enable !== 1'b0) begin
      errors++; $display("FAIL mid_reset got line %b tx %b pop %b want %b 0 0",
                         {bus.d_plus, bus.d_minus}, bus.transmitting, bus.fifo_r_enable, J);
    end
    rst = 1'b0;
    @(negedge clk);
    wr = rd;
    push(8'hA5);
    start_pkt();
    capture(-1, -1, 8'h00);
    checks++;
    if (cap_len !== 152) begin
      errors++; $display("FAIL post_reset_len got %0d want 152", cap_len);
    end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (!bit_ok(b, e[b])) begin
        errors++; $display("FAIL post_reset_sync%0d got %b want %b", b, cap_sym[b*C + C/2], e[b]);
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rd           = 0;
    wr           = 0;
    pop_total    = 0;
    bad_pops     = 0;
    bus.tx_start = 1'b0;
    rst          = 1'b1;

    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty_start();
    test_start_ignored();
    test_late_refill();
    test_reset_mid_data();

    checks++;
    if (bad_pops !== 0) begin
      errors++; $display("FAIL pop_when_empty got %0d want 0", bad_pops);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
